// File: rtl/alu_issue_stage.sv
// Operand issue stage feeding the ALU: latches one decoded instruction, merges and
// forwards in-flight results per byte lane, and holds the pipe while a load is outstanding.
module alu_issue_stage #(
  parameter int RA_W     = 4,
  parameter int LOAD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            dec_valid,
  input  logic [RA_W-1:0] dec_src_a,
  input  logic [RA_W-1:0] dec_src_b,
  input  logic [RA_W-1:0] dec_dst,
  input  logic            dec_h_en,
  input  logic            dec_l_en,
  input  logic            dec_load,
  input  logic [3:0]      dec_alu_op,
  input  logic            dec_set_cc,
  input  logic [7:0]      dec_I_field,
  input  logic [15:0]     rf_data_a,
  input  logic [15:0]     rf_data_b,
  input  logic            wb_we_h,
  input  logic            wb_we_l,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [15:0]     wb_data,
  input  logic [15:0]     alu_out,
  output logic            dec_stall,
  output logic            data_hazard,
  output logic [15:0]     in_a,
  output logic [15:0]     in_b,
  output logic [3:0]      alu_op,
  output logic [7:0]      I_field,
  output logic            h_en,
  output logic            l_en,
  output logic            set_cc,
  output logic            dbg_state
);

  localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               is_valid;
  logic [RA_W-1:0]    is_src_a, is_src_b, is_dst;
  logic               is_h, is_l, is_load;
  logic [3:0]         is_op;
  logic               is_cc;
  logic [7:0]         is_imm;
  logic [15:0]        is_a, is_b;

  logic               ex_valid;
  logic [RA_W-1:0]    ex_dst;
  logic               ex_wr_h, ex_wr_l, ex_load;

  logic [RA_W-1:0]    ld_dst;
  logic               ld_wr_h, ld_wr_l;

  logic               advance, capture, load_use, wb_rdy;
  logic               need_h, need_l;
  logic [15:0]        cap_a, cap_b;
  logic               ex_fwd;
  logic               a_ex_h, a_ex_l, b_ex_h, b_ex_l;
  logic               a_wb_h, a_wb_l, b_wb_h, b_wb_l;

  // Handshake: the decoder presents an instruction with dec_valid and must hold it
  // unchanged while dec_stall is high; it is consumed on any edge with dec_valid=1,
  // dec_stall=0 and flush=0.
  assign advance = ~data_hazard;
  assign capture = dec_valid & ~dec_stall & ~flush;
  assign dec_stall = data_hazard | (is_valid & ~advance);
  assign dbg_state = (state_q == STALL);

  assign cap_a = {(wb_we_h && wb_addr == dec_src_a) ? wb_data[15:8] : rf_data_a[15:8],
                  (wb_we_l && wb_addr == dec_src_a) ? wb_data[7:0]  : rf_data_a[7:0]};
  assign cap_b = {(wb_we_h && wb_addr == dec_src_b) ? wb_data[15:8] : rf_data_b[15:8],
                  (wb_we_l && wb_addr == dec_src_b) ? wb_data[7:0]  : rf_data_b[7:0]};

  assign load_use = is_valid & ex_valid & ex_load &
                    ((is_src_a == ex_dst) | (is_src_b == ex_dst));

  // Lanes of the pending load that the held instruction actually reads.
  assign need_h = ld_wr_h & ((is_src_a == ld_dst) | (is_src_b == ld_dst));
  assign need_l = ld_wr_l & ((is_src_a == ld_dst) | (is_src_b == ld_dst));
  assign wb_rdy = (~need_h | (wb_we_h & (wb_addr == ld_dst))) &
                  (~need_l | (wb_we_l & (wb_addr == ld_dst)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_hazard = 1'b0;
    case (state_q)
      RUN: begin
        if (load_use) begin
          data_hazard = 1'b1;
          state_d     = STALL;
          cnt_d       = CNT_W'(LOAD_LAT - 1);
        end
      end
      STALL: begin
        if (cnt_q != '0) begin
          data_hazard = 1'b1;
          cnt_d       = cnt_q - CNT_W'(1);
        end else if (!wb_rdy) begin
          data_hazard = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (flush) begin
      state_d = RUN;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      is_valid <= 1'b0;
      is_src_a <= '0;
      is_src_b <= '0;
      is_dst   <= '0;
      is_h     <= 1'b1;
      is_l     <= 1'b1;
      is_load  <= 1'b0;
      is_op    <= 4'b0111;
      is_cc    <= 1'b0;
      is_imm   <= '0;
      is_a     <= '0;
      is_b     <= '0;
      ex_valid <= 1'b0;
      ex_dst   <= '0;
      ex_wr_h  <= 1'b0;
      ex_wr_l  <= 1'b0;
      ex_load  <= 1'b0;
      ld_dst   <= '0;
      ld_wr_h  <= 1'b0;
      ld_wr_l  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      if (flush)           is_valid <= 1'b0;
      else if (!dec_stall) is_valid <= dec_valid;

      if (capture) begin
        is_src_a <= dec_src_a;
        is_src_b <= dec_src_b;
        is_dst   <= dec_dst;
        is_h     <= dec_h_en;
        is_l     <= dec_l_en;
        is_load  <= dec_load;
        is_op    <= dec_alu_op;
        is_cc    <= dec_set_cc;
        is_imm   <= dec_I_field;
        is_a     <= cap_a;
        is_b     <= cap_b;
      end

      // A held instruction leaves a bubble in EX behind the retiring one.
      ex_valid <= ~flush & advance & is_valid;
      if (advance) begin
        ex_dst  <= is_dst;
        ex_wr_h <= is_h | ~is_l;
        ex_wr_l <= is_l | ~is_h;
        ex_load <= is_load;
      end

      if (state_q == RUN && load_use) begin
        ld_dst  <= ex_dst;
        ld_wr_h <= ex_wr_h;
        ld_wr_l <= ex_wr_l;
      end
    end
  end

  function automatic logic [7:0] fwd_byte(input logic ex_hit, input logic [7:0] ex_b,
                                          input logic wb_hit, input logic [7:0] wb_b,
                                          input logic [7:0] cap_b_in);
    if (ex_hit)      return ex_b;
    else if (wb_hit) return wb_b;
    else             return cap_b_in;
  endfunction

  assign ex_fwd = ex_valid & ~ex_load;
  assign a_ex_h = ex_fwd & ex_wr_h & (ex_dst == is_src_a);
  assign a_ex_l = ex_fwd & ex_wr_l & (ex_dst == is_src_a);
  assign b_ex_h = ex_fwd & ex_wr_h & (ex_dst == is_src_b);
  assign b_ex_l = ex_fwd & ex_wr_l & (ex_dst == is_src_b);
  assign a_wb_h = wb_we_h & (wb_addr == is_src_a);
  assign a_wb_l = wb_we_l & (wb_addr == is_src_a);
  assign b_wb_h = wb_we_h & (wb_addr == is_src_b);
  assign b_wb_l = wb_we_l & (wb_addr == is_src_b);

  // An empty slot presents an ALU nop that leaves the condition codes alone.
  always_comb begin
    in_a    = '0;
    in_b    = '0;
    alu_op  = 4'b0111;
    I_field = '0;
    h_en    = 1'b1;
    l_en    = 1'b1;
    set_cc  = 1'b0;
    if (is_valid) begin
      in_a    = {fwd_byte(a_ex_h, alu_out[15:8], a_wb_h, wb_data[15:8], is_a[15:8]),
                 fwd_byte(a_ex_l, alu_out[7:0],  a_wb_l, wb_data[7:0],  is_a[7:0])};
      in_b    = {fwd_byte(b_ex_h, alu_out[15:8], b_wb_h, wb_data[15:8], is_b[15:8]),
                 fwd_byte(b_ex_l, alu_out[7:0],  b_wb_l, wb_data[7:0],  is_b[7:0])};
      alu_op  = is_op;
      I_field = is_imm;
      h_en    = is_h;
      l_en    = is_l;
      set_cc  = is_cc;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios followed by random traffic, all
// outputs compared every cycle against an instruction-level reference model.
module tb_alu_issue_stage;
  localparam int RA_W     = 4;
  localparam int LOAD_LAT = 2;

  logic clk = 1'b0;
  logic rst, flush, dec_valid;
  logic [RA_W-1:0] dec_src_a, dec_src_b, dec_dst, wb_addr;
  logic dec_h_en, dec_l_en, dec_load, dec_set_cc, wb_we_h, wb_we_l;
  logic [3:0] dec_alu_op;
  logic [7:0] dec_I_field;
  logic [15:0] rf_data_a, rf_data_b, wb_data, alu_out;
  logic dec_stall, data_hazard, h_en, l_en, set_cc, dbg_state;
  logic [15:0] in_a, in_b;
  logic [3:0] alu_op;
  logic [7:0] I_field;

  always #5 clk = ~clk;

  alu_issue_stage #(.RA_W(RA_W), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .dec_valid(dec_valid),
    .dec_src_a(dec_src_a), .dec_src_b(dec_src_b), .dec_dst(dec_dst),
    .dec_h_en(dec_h_en), .dec_l_en(dec_l_en), .dec_load(dec_load),
    .dec_alu_op(dec_alu_op), .dec_set_cc(dec_set_cc), .dec_I_field(dec_I_field),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .wb_we_h(wb_we_h), .wb_we_l(wb_we_l),
    .wb_addr(wb_addr), .wb_data(wb_data), .alu_out(alu_out), .dec_stall(dec_stall),
    .data_hazard(data_hazard), .in_a(in_a), .in_b(in_b), .alu_op(alu_op),
    .I_field(I_field), .h_en(h_en), .l_en(l_en), .set_cc(set_cc), .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic v;
    logic [RA_W-1:0] sa, sb, dst;
    logic h, l, ld;
    logic [3:0] op;
    logic cc;
    logic [7:0] imm;
    logic [15:0] a, b;
  } ins_t;

  // Reference model: the instruction sitting at the ALU, the one ahead of it,
  // and the outstanding load being waited on (with cycles spent waiting).
  ins_t m_is = '0;
  ins_t m_ex = '0;
  bit m_stall = 1'b0;
  int m_age = 0;
  logic [RA_W-1:0] m_ld_dst = '0;
  bit m_ld_h = 1'b0, m_ld_l = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit writes_hi(input ins_t i);
    return i.h || (!i.h && !i.l);
  endfunction

  function automatic bit writes_lo(input ins_t i);
    return i.l || (!i.h && !i.l);
  endfunction

  function automatic logic [7:0] exp_byte(input logic [RA_W-1:0] src, input bit hi,
                                          input logic [15:0] cap);
    if (m_ex.v && !m_ex.ld && m_ex.dst == src && (hi ? writes_hi(m_ex) : writes_lo(m_ex)))
      return hi ? alu_out[15:8] : alu_out[7:0];
    if ((hi ? wb_we_h : wb_we_l) && wb_addr == src)
      return hi ? wb_data[15:8] : wb_data[7:0];
    return hi ? cap[15:8] : cap[7:0];
  endfunction

  function automatic bit wb_covers();
    bit reads = (m_is.sa == m_ld_dst) || (m_is.sb == m_ld_dst);
    bit ok = 1'b1;
    if (reads && m_ld_h && !(wb_we_h && wb_addr == m_ld_dst)) ok = 1'b0;
    if (reads && m_ld_l && !(wb_we_l && wb_addr == m_ld_dst)) ok = 1'b0;
    return ok;
  endfunction

  function automatic bit exp_hazard();
    if (!m_stall)
      return m_is.v && m_ex.v && m_ex.ld && (m_is.sa == m_ex.dst || m_is.sb == m_ex.dst);
    // LOAD_LAT hazard cycles at minimum (detection + LOAD_LAT-1), longer if wb is late.
    return (m_age + 1 < LOAD_LAT) || !wb_covers();
  endfunction

  function automatic logic [15:0] merge(input logic [RA_W-1:0] src, input logic [15:0] rf);
    return {(wb_we_h && wb_addr == src) ? wb_data[15:8] : rf[15:8],
            (wb_we_l && wb_addr == src) ? wb_data[7:0]  : rf[7:0]};
  endfunction

  task automatic sample();
    bit haz;
    @(negedge clk);
    haz = exp_hazard();
    chk("data_hazard", 16'(data_hazard), 16'(haz));
    chk("dec_stall", 16'(dec_stall), 16'(haz));
    chk("alu_op", 16'(alu_op), m_is.v ? 16'(m_is.op) : 16'h7);
    chk("set_cc", 16'(set_cc), m_is.v ? 16'(m_is.cc) : 16'h0);
    chk("h_en", 16'(h_en), m_is.v ? 16'(m_is.h) : 16'h1);
    chk("l_en", 16'(l_en), m_is.v ? 16'(m_is.l) : 16'h1);
    chk("I_field", 16'(I_field), m_is.v ? 16'(m_is.imm) : 16'h0);
    chk("in_a", in_a, m_is.v ? {exp_byte(m_is.sa, 1'b1, m_is.a), exp_byte(m_is.sa, 1'b0, m_is.a)} : 16'h0);
    chk("in_b", in_b, m_is.v ? {exp_byte(m_is.sb, 1'b1, m_is.b), exp_byte(m_is.sb, 1'b0, m_is.b)} : 16'h0);
  endtask

  task automatic tick();
    bit haz;
    haz = exp_hazard();
    @(posedge clk);
    if (rst) begin
      m_is = '0; m_ex = '0; m_stall = 1'b0; m_age = 0;
    end else if (flush) begin
      m_is.v = 1'b0; m_ex.v = 1'b0; m_stall = 1'b0; m_age = 0;
    end else begin
      if (!m_stall && haz) begin
        m_stall = 1'b1; m_age = 0;
        m_ld_dst = m_ex.dst; m_ld_h = writes_hi(m_ex); m_ld_l = writes_lo(m_ex);
      end else if (m_stall) begin
        if (haz) m_age++;
        else m_stall = 1'b0;
      end
      if (!haz) begin
        m_ex = m_is;
        m_is.v = dec_valid;
        if (dec_valid) begin
          m_is = '{v: 1'b1, sa: dec_src_a, sb: dec_src_b, dst: dec_dst, h: dec_h_en,
                   l: dec_l_en, ld: dec_load, op: dec_alu_op, cc: dec_set_cc,
                   imm: dec_I_field, a: merge(dec_src_a, rf_data_a), b: merge(dec_src_b, rf_data_b)};
        end
      end else begin
        m_ex.v = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle();
    dec_valid = 1'b0; flush = 1'b0; wb_we_h = 1'b0; wb_we_l = 1'b0;
  endtask

  task automatic set_dec(input logic [RA_W-1:0] sa, input logic [RA_W-1:0] sb,
                         input logic [RA_W-1:0] dst, input logic h, input logic l,
                         input logic ld, input logic [3:0] op, input logic [7:0] imm);
    dec_valid = 1'b1; dec_src_a = sa; dec_src_b = sb; dec_dst = dst;
    dec_h_en = h; dec_l_en = l; dec_load = ld; dec_alu_op = op;
    dec_set_cc = 1'b1; dec_I_field = imm;
  endtask

  task automatic load_then_use();
    set_dec(4'd1, 4'd2, 4'd5, 1'b1, 1'b1, 1'b1, 4'd3, 8'h10);
    sample(); tick();
    set_dec(4'd5, 4'd0, 4'd6, 1'b1, 1'b1, 1'b0, 4'd1, 8'h20);
    sample(); tick();
    idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hazard"}, 16'(data_hazard), 16'h0);
    chk({tag, "_stall"}, 16'(dec_stall), 16'h0);
    chk({tag, "_op"}, 16'(alu_op), 16'h7);
    chk({tag, "_cc"}, 16'(set_cc), 16'h0);
    chk({tag, "_hl"}, 16'({h_en, l_en}), 16'h3);
    chk({tag, "_ab"}, in_a | in_b, 16'h0);
    chk({tag, "_imm"}, 16'(I_field), 16'h0);
  endtask

  initial begin
    rst = 1'b1; idle();
    dec_src_a = '0; dec_src_b = '0; dec_dst = '0; dec_h_en = 1'b1; dec_l_en = 1'b1;
    dec_load = 1'b0; dec_alu_op = '0; dec_set_cc = 1'b0; dec_I_field = '0;
    rf_data_a = '0; rf_data_b = '0; wb_addr = '0; wb_data = '0; alu_out = '0;
    tick(); tick();
    rst = 1'b0;
    sample();
    check_reset_outputs("reset");
    tick();

    // Back-to-back dependent ADDs forwarded from alu_out.
    set_dec(4'd2, 4'd3, 4'd1, 1'b1, 1'b1, 1'b0, 4'd1, 8'h11);
    sample(); tick();
    set_dec(4'd1, 4'd1, 4'd4, 1'b1, 1'b1, 1'b0, 4'd1, 8'h22);
    sample(); tick();
    idle(); alu_out = 16'h1234;
    sample();
    chk("fwd_ex_a", in_a, 16'h1234);
    chk("fwd_ex_b", in_b, 16'h1234);
    chk("fwd_ex_nohaz", 16'(data_hazard), 16'h0);
    tick();

    // High-byte-only EX result merges with captured low byte.
    set_dec(4'd2, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0, 4'd2, 8'h33);
    sample(); tick();
    set_dec(4'd1, 4'd7, 4'd9, 1'b1, 1'b1, 1'b0, 4'd1, 8'h44);
    rf_data_a = 16'h00CD;
    sample(); tick();
    idle(); alu_out = 16'hAB00;
    sample();
    chk("lane_merge", in_a, 16'hABCD);
    tick();

    // Writeback bypass at capture time.
    set_dec(4'd2, 4'd3, 4'd10, 1'b1, 1'b1, 1'b0, 4'd1, 8'h55);
    rf_data_a = 16'h1100; wb_addr = 4'd2; wb_we_l = 1'b1; wb_data = 16'h0077;
    sample(); tick();
    idle();
    sample();
    chk("wb_capture", in_a, 16'h1177);
    tick();

    // Load-use stall released by the writeback.
    load_then_use();
    sample(); chk("lu_haz1", 16'(data_hazard), 16'h1); tick();
    sample(); chk("lu_haz2", 16'(data_hazard), 16'h1); tick();
    wb_addr = 4'd5; wb_we_h = 1'b1; wb_we_l = 1'b1; wb_data = 16'hBEEF;
    sample();
    chk("lu_release", 16'(data_hazard), 16'h0);
    chk("lu_wb_a", in_a, 16'hBEEF);
    chk("lu_dec_stall", 16'(dec_stall), 16'h0);
    tick();
    idle(); sample(); tick();

    // Flush during stall.
    load_then_use();
    sample(); tick();
    flush = 1'b1;
    sample(); tick();
    flush = 1'b0;
    sample();
    chk("flush_haz", 16'(data_hazard), 16'h0);
    chk("flush_op", 16'(alu_op), 16'h7);
    chk("flush_cc", 16'(set_cc), 16'h0);
    tick();

    // Reset during stall.
    load_then_use();
    sample(); tick();
    rst = 1'b1;
    sample(); tick();
    rst = 1'b0;
    sample();
    check_reset_outputs("rst_stall");
    tick();

    // Random traffic on a small register window so hazards and forwards collide often.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 15) == 0);
      dec_valid = ($urandom_range(0, 3) != 0);
      dec_src_a = RA_W'($urandom_range(0, 3));
      dec_src_b = RA_W'($urandom_range(0, 3));
      dec_dst = RA_W'($urandom_range(0, 3));
      dec_h_en = 1'($urandom_range(0, 1));
      dec_l_en = 1'($urandom_range(0, 1));
      dec_load = ($urandom_range(0, 3) == 0);
      dec_alu_op = 4'($urandom);
      dec_set_cc = 1'($urandom_range(0, 1));
      dec_I_field = 8'($urandom);
      rf_data_a = 16'($urandom);
      rf_data_b = 16'($urandom);
      wb_we_h = 1'($urandom_range(0, 1));
      wb_we_l = 1'($urandom_range(0, 1));
      wb_addr = RA_W'($urandom_range(0, 3));
      wb_data = 16'($urandom);
      alu_out = 16'($urandom);
      sample();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
